// File: rtl/shift_seq_unit_pkg.sv
// Shared constants for the sequential shifter and the instruction decoder.
// Latency: n/a (types, limits and a step-count helper only).
// Backpressure: n/a.
package shift_seq_unit_pkg;

   // Shift-type field encoding (Sh)
   typedef enum logic [1:0] {
      SH_LSL = 2'b00,
      SH_LSR = 2'b01,
      SH_ASR = 2'b10,
      SH_ROR = 2'b11
   } sh_t;

   // Sequencer states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   // Beyond these step counts the logical/arithmetic results stop changing
   localparam int SAT_LOGICAL = 33;
   localparam int SAT_ARITH   = 32;

   // Number of 1-bit steps needed for a register-specified amount
   function automatic logic [5:0] step_count(input sh_t sh, input logic [7:0] n);
      logic [5:0] k;
      case (sh)
         SH_LSL, SH_LSR: k = (n > 8'(SAT_LOGICAL)) ? 6'(SAT_LOGICAL) : n[5:0];
         SH_ASR:         k = (n > 8'(SAT_ARITH))   ? 6'(SAT_ARITH)   : n[5:0];
         default:        k = {1'b0, n[4:0]};
      endcase
      return k;
   endfunction

endpackage

// File: rtl/shift_seq_unit_if.sv
// Request/result bundle of the sequential shifter.
// Latency: n/a (wiring only).
// Backpressure: none; requests presented outside IDLE are dropped by the slave.
interface shift_seq_unit_if;
   logic        Start;
   logic [1:0]  Sh;
   logic [7:0]  ShAmt8;
   logic [31:0] ShIn;
   logic        CarryIn;
   logic [31:0] ShOut;
   logic        CarryOut;
   logic        Busy;
   logic        Done;

   modport master (
      output Start, Sh, ShAmt8, ShIn, CarryIn,
      input  ShOut, CarryOut, Busy, Done
   );

   modport slave (
      input  Start, Sh, ShAmt8, ShIn, CarryIn,
      output ShOut, CarryOut, Busy, Done
   );
endinterface

// File: rtl/shift_step_1bit.sv
// One-position shift/rotate of a 32-bit value with the carry it produces.
// Latency: combinational.
// Backpressure: none.
module shift_step_1bit
   import shift_seq_unit_pkg::*;
(
   input  sh_t         sh,
   input  logic [31:0] val_in,
   output logic [31:0] val_out,
   output logic        carry
);

   // Select the single-bit move and the bit that falls out of it
   always_comb begin
      val_out = val_in;
      carry   = 1'b0;
      case (sh)
         SH_LSL: begin val_out = {val_in[30:0], 1'b0};      carry = val_in[31]; end
         SH_LSR: begin val_out = {1'b0, val_in[31:1]};      carry = val_in[0];  end
         SH_ASR: begin val_out = {val_in[31], val_in[31:1]}; carry = val_in[0];  end
         SH_ROR: begin val_out = {val_in[0], val_in[31:1]};  carry = val_in[0];  end
         default: begin val_out = val_in; carry = 1'b0; end
      endcase
   end

endmodule

// File: rtl/shift_seq_unit.sv
// Sequential shifter: one bit per clock, saturating the step count at 32/33.
// Latency: k+1 clocks from the accepting edge to Done (k = step count, max 33).
// Backpressure: Start is taken only in IDLE; pulses while Busy are dropped.
module shift_seq_unit
   import shift_seq_unit_pkg::*;
(
   input  logic              CLK,
   input  logic              RESET,
   shift_seq_unit_if.slave   bus
);

   state_t      state;
   state_t      state_nxt;
   logic [5:0]  cnt;
   logic [31:0] val;
   logic        carry;
   sh_t         sh_q;
   logic [31:0] step_val;
   logic        step_carry;
   logic [5:0]  k_req;

   assign k_req = step_count(sh_t'(bus.Sh), bus.ShAmt8);

   shift_step_1bit u_step (
      .sh      (sh_q),
      .val_in  (val),
      .val_out (step_val),
      .carry   (step_carry)
   );

   // Next-state: zero-step requests skip straight to DONE
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (bus.Start) state_nxt = (k_req == 6'd0) ? ST_DONE : ST_SHIFT;
         ST_SHIFT: if (cnt == 6'd1) state_nxt = ST_DONE;
         ST_DONE:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge CLK) begin
      if (RESET) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   // Operand capture on acceptance, then one step per SHIFT cycle
   always_ff @(posedge CLK) begin
      if (RESET) begin
         cnt   <= 6'd0;
         val   <= 32'd0;
         carry <= 1'b0;
         sh_q  <= SH_LSL;
      end else begin
         case (state)
            ST_IDLE: if (bus.Start) begin
               sh_q <= sh_t'(bus.Sh);
               val  <= bus.ShIn;
               cnt  <= k_req;
               // Only matters when no step runs: n=0 keeps C, a ROR by a
               // non-zero multiple of 32 reports bit 31.
               carry <= (bus.ShAmt8 == 8'd0) ? bus.CarryIn : bus.ShIn[31];
            end
            ST_SHIFT: begin
               val   <= step_val;
               carry <= step_carry;
               cnt   <= cnt - 6'd1;
            end
            default: ;
         endcase
      end
   end

   assign bus.ShOut    = val;
   assign bus.CarryOut = carry;
   assign bus.Busy     = (state != ST_IDLE);
   assign bus.Done     = (state == ST_DONE);

endmodule

// File: tb/tb_shift_seq_unit.sv
// Scoreboard bench for shift_seq_unit: directed operations push expectations,
// a negedge monitor pops one per Done and compares result, carry and latency.
module tb_shift_seq_unit;

   logic CLK = 1'b0;
   logic RESET;
   int   cyc = 0;
   int   vectors = 0;
   int   miscompares = 0;

   typedef struct {
      logic [31:0] out;
      logic        c;
      int          lat;
      int          start;
      string       name;
   } exp_t;

   exp_t exp_q[$];

   shift_seq_unit_if bus();

   shift_seq_unit dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (bus)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %h required %h", name, act, req);
      end
   endtask

   // Monitor: every Done must match the oldest outstanding expectation
   always @(negedge CLK) begin
      exp_t e;
      if (RESET === 1'b0 && bus.Done === 1'b1) begin
         if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_done: got Done=1 with ShOut %h, required no Done", bus.ShOut);
         end else begin
            e = exp_q.pop_front();
            check({e.name, "_shout"},   bus.ShOut, e.out);
            check({e.name, "_carry"},   {31'd0, bus.CarryOut}, {31'd0, e.c});
            check({e.name, "_latency"}, cyc - e.start, e.lat);
            check({e.name, "_busy"},    {31'd0, bus.Busy}, 32'd1);
         end
      end
   end

   task automatic push_exp(input string name, input logic [31:0] o, input logic c, input int lat);
      exp_t e;
      e.out = o; e.c = c; e.lat = lat; e.start = cyc; e.name = name;
      exp_q.push_back(e);
   endtask

   task automatic drive(input logic [1:0] sh, input logic [7:0] n, input logic [31:0] din, input logic cin);
      bus.Sh = sh; bus.ShAmt8 = n; bus.ShIn = din; bus.CarryIn = cin; bus.Start = 1'b1;
   endtask

   task automatic wait_idle(input string name);
      bit idle = 0;
      for (int i = 0; i < 40; i++) begin
         if (bus.Busy === 1'b0) begin idle = 1; break; end
         @(negedge CLK);
      end
      if (!idle) begin
         vectors++;
         miscompares++;
         $display("FAIL %s_timeout: got Busy still high after 40 cycles, required idle", name);
      end
   endtask

   task automatic issue(input string name, input logic [1:0] sh, input logic [7:0] n,
                        input logic [31:0] din, input logic cin,
                        input logic [31:0] eo, input logic ec, input int elat);
      @(negedge CLK);
      push_exp(name, eo, ec, elat);
      drive(sh, n, din, cin);
      @(negedge CLK);
      bus.Start = 1'b0;
      wait_idle(name);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish by 100us, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      RESET = 1'b1;
      bus.Start = 1'b0; bus.Sh = 2'b00; bus.ShAmt8 = 8'd0; bus.ShIn = 32'd0; bus.CarryIn = 1'b0;
      repeat (3) @(negedge CLK);
      check("rst_shout", bus.ShOut, 32'd0);
      check("rst_carry", {31'd0, bus.CarryOut}, 32'd0);
      check("rst_busy",  {31'd0, bus.Busy}, 32'd0);
      check("rst_done",  {31'd0, bus.Done}, 32'd0);
      RESET = 1'b0;

      //     name          Sh     n      ShIn          C     ShOut         Cout lat
      issue("lsl4",     2'b00, 8'd4,   32'h0000000F, 1'b0, 32'h000000F0, 1'b0, 5);
      issue("lsr32",    2'b01, 8'd32,  32'h80000001, 1'b0, 32'h00000000, 1'b1, 33);
      issue("lsl40",    2'b00, 8'd40,  32'h80000001, 1'b1, 32'h00000000, 1'b0, 34);
      issue("asr200",   2'b10, 8'd200, 32'h80000000, 1'b0, 32'hFFFFFFFF, 1'b1, 33);
      issue("ror36",    2'b11, 8'd36,  32'h00000001, 1'b1, 32'h10000000, 1'b0, 5);
      issue("ror32",    2'b11, 8'd32,  32'h80000000, 1'b0, 32'h80000000, 1'b1, 1);
      issue("n0_lsl",   2'b00, 8'd0,   32'h1234ABCD, 1'b1, 32'h1234ABCD, 1'b1, 1);
      issue("n0_asr",   2'b10, 8'd0,   32'h8765FFFF, 1'b0, 32'h8765FFFF, 1'b0, 1);
      issue("lsl32",    2'b00, 8'd32,  32'h00000001, 1'b0, 32'h00000000, 1'b1, 33);
      issue("lsl1",     2'b00, 8'd1,   32'h80000000, 1'b0, 32'h00000000, 1'b1, 2);
      issue("lsr1",     2'b01, 8'd1,   32'h00000003, 1'b0, 32'h00000001, 1'b1, 2);
      issue("asr4",     2'b10, 8'd4,   32'h80000018, 1'b0, 32'hF8000001, 1'b1, 5);
      issue("ror8",     2'b11, 8'd8,   32'h000000A5, 1'b0, 32'hA5000000, 1'b1, 9);
      issue("lsr33",    2'b01, 8'd33,  32'hFFFFFFFF, 1'b1, 32'h00000000, 1'b0, 34);
      issue("asr31",    2'b10, 8'd31,  32'h7FFFFFFF, 1'b0, 32'h00000000, 1'b1, 32);

      // Result holds after Done
      repeat (3) @(negedge CLK);
      check("hold_shout", bus.ShOut, 32'h00000000);
      check("hold_carry", {31'd0, bus.CarryOut}, 32'd1);

      // Start re-pulsed during SHIFT is ignored
      @(negedge CLK);
      push_exp("ign_shift", 32'h00000400, 1'b0, 11);
      drive(2'b00, 8'd10, 32'h00000001, 1'b0);
      @(negedge CLK);
      bus.Start = 1'b0;
      repeat (3) @(negedge CLK);
      drive(2'b01, 8'd1, 32'hFFFFFFFF, 1'b1);
      @(negedge CLK);
      bus.Start = 1'b0;
      wait_idle("ign_shift");

      // Start in the Done cycle is dropped; the next IDLE cycle accepts
      @(negedge CLK);
      push_exp("pre_done", 32'h80000000, 1'b1, 1);
      drive(2'b11, 8'd32, 32'h80000000, 1'b0);
      @(negedge CLK);
      drive(2'b01, 8'd1, 32'hFFFFFFFF, 1'b1);
      @(negedge CLK);
      check("done_start_ignored_busy", {31'd0, bus.Busy}, 32'd0);
      check("done_start_ignored_shout", bus.ShOut, 32'h80000000);
      push_exp("after_done", 32'hDEADBEEF, 1'b0, 1);
      drive(2'b00, 8'd0, 32'hDEADBEEF, 1'b0);
      @(negedge CLK);
      bus.Start = 1'b0;
      wait_idle("after_done");

      // Reset part-way through LSL n=10 aborts without Done
      @(negedge CLK);
      drive(2'b00, 8'd10, 32'h0000000F, 1'b1);
      @(negedge CLK);
      bus.Start = 1'b0;
      repeat (2) @(negedge CLK);
      RESET = 1'b1;
      @(negedge CLK);
      RESET = 1'b0;
      check("abort_shout", bus.ShOut, 32'd0);
      check("abort_carry", {31'd0, bus.CarryOut}, 32'd0);
      check("abort_busy",  {31'd0, bus.Busy}, 32'd0);
      check("abort_done",  {31'd0, bus.Done}, 32'd0);
      repeat (15) @(negedge CLK);

      // Reset wins over a coincident Start
      drive(2'b00, 8'd3, 32'h00000005, 1'b1);
      RESET = 1'b1;
      @(negedge CLK);
      RESET = 1'b0;
      bus.Start = 1'b0;
      check("rst_start_busy",  {31'd0, bus.Busy}, 32'd0);
      check("rst_start_shout", bus.ShOut, 32'd0);
      repeat (6) @(negedge CLK);

      check("pending_expectations", exp_q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/shift_seq_unit.md
SHIFT_SEQ_UNIT -- requirements
Module: shift_seq_unit

Interface
REQ-001 The block SHALL run on one clock; reset is synchronous and active-high (ports CLK, RESET).
REQ-002 CLK  in  1  rising-edge clock for all state.
REQ-003 RESET  in  1  synchronous, active-high; sampled on CLK rising edge.
REQ-004 Start  in  1  request pulse; operands sampled with it.
REQ-005 Sh  in  2  shift type: 00 LSL, 01 LSR, 10 ASR, 11 ROR.
REQ-006 ShAmt8  in  8  register-specified shift amount n (Rs[7:0]), 0..255.
REQ-007 ShIn  in  32  operand to shift.
REQ-008 CarryIn  in  1  current C flag, returned when n=0.
REQ-009 ShOut  out  32  shift result.
REQ-010 CarryOut  out  1  shifter carry-out.
REQ-011 Busy  out  1  high from the cycle after acceptance through the Done cycle.
REQ-012 Done  out  1  one-cycle pulse; ShOut/CarryOut valid from this cycle.

Function
REQ-013 States SHALL be IDLE, SHIFT, DONE; Start SHALL be accepted only in IDLE and ignored in SHIFT/DONE.
REQ-014 On acceptance the block SHALL latch Sh, ShIn, CarryIn and step count k: LSL/LSR min(n,33); ASR min(n,32); ROR n[4:0].
REQ-015 IDLE->SHIFT if k>0, IDLE->DONE if k=0; SHIFT performs exactly one 1-bit step per cycle, ->DONE after k steps; DONE->IDLE unconditionally.
REQ-016 Latency SHALL be k+1 clocks from the Start-sampling edge to Done high; maximum 34.
REQ-017 LSL step: result<<1, carry=old bit31; LSR step: result>>1 zero-fill, carry=old bit0; ASR step: sign-fill, carry=old bit0; ROR step: rotate right 1, carry=new bit31.
REQ-018 n=0 (any Sh): ShOut=ShIn, CarryOut=CarryIn.
REQ-019 LSL/LSR n=32: ShOut=0, CarryOut=ShIn[0]/ShIn[31]; n>32: ShOut=0, CarryOut=0.
REQ-020 ASR n>=32: ShOut=32 copies of ShIn[31], CarryOut=ShIn[31].
REQ-021 ROR n!=0 with n[4:0]=0: ShOut=ShIn, CarryOut=ShIn[31] (k=0 path, distinct from n=0).
REQ-022 ShOut/CarryOut SHALL hold their last result until the next accepted Start; intermediate values are not guaranteed valid while Busy before Done.
REQ-023 Start asserted in the Done cycle SHALL be ignored; Start in the following IDLE cycle SHALL be accepted.

Reset
REQ-024 RESET SHALL force IDLE with ShOut=0, CarryOut=0, Busy=0, Done=0, counter=0.
REQ-025 RESET mid-operation SHALL abort without Done; RESET overrides a coincident Start.

Structure
REQ-026 Sh encodings (LSL/LSR/ASR/ROR), state encodings and saturation limits (32, 33) SHALL live in a shared constants header used by this block and the decoder.
REQ-027 The 1-bit step datapath SHALL be a combinational sub-module shift_step_1bit (inputs Sh, value; outputs value, carry).
REQ-028 Counter SHALL be 6 bits; no multiplier or barrel structure.

Verification
REQ-029 LSL n=4, ShIn=0x0000000F -> ShOut=0x000000F0, CarryOut=0, Done 5 clocks after Start.
REQ-030 LSR n=32, ShIn=0x80000001 -> ShOut=0, CarryOut=1, latency 33; LSL n=40 same ShIn -> 0, CarryOut=0, latency 34.
REQ-031 ASR n=200, ShIn=0x80000000 -> ShOut=0xFFFFFFFF, CarryOut=1, latency 33.
REQ-032 ROR n=36, ShIn=0x00000001 -> ShOut=0x10000000, CarryOut=0, latency 5; ROR n=32, ShIn=0x80000000 -> ShOut=0x80000000, CarryOut=1, latency 1.
REQ-033 n=0, CarryIn=1, ShIn=0x1234ABCD -> ShOut=0x1234ABCD, CarryOut=1, Done 1 clock after Start.
REQ-034 Start re-pulsed during SHIFT ignored (result unchanged); RESET at step 3 of LSL n=10 -> IDLE, no Done, all outputs 0.
